// File: rtl/restoring_divider_seq_if.sv
// Request/response bundle for restoring_divider_seq.
//   start, signed_op, A, B : request side, driven by the master
//   Q, R, valid, busy      : result side, driven by the divider (slave)
interface restoring_divider_seq_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic         signed_op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         valid;
  logic         busy;

  modport master (
    output start, signed_op, A, B,
    input  Q, R, valid, busy
  );

  modport slave (
    input  start, signed_op, A, B,
    output Q, R, valid, busy
  );
endinterface

// File: rtl/restoring_divider_seq.sv
// Sequential radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Divides magnitudes one quotient bit per cycle, then applies the sign and the
// divide-by-zero / signed-overflow fix-ups, and pulses valid for one cycle.
// Ports:
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous active-high reset
//   bus (slave)   : start/signed_op/A/B request, Q/R/valid/busy result
// Optional feature: define DIV_EARLY_OUT_EN to skip the iterations when the
// divisor is zero or the signed op overflows (result ready one edge after FIX
// instead of after 32 CALC edges). Results are the same either way.
module restoring_divider_seq #(
  parameter int unsigned N = 32
) (
  input logic                    clk,
  input logic                    rst,
  restoring_divider_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    rem_q;   // partial remainder
  logic [N-1:0]    quo_q;   // dividend shifts out the top, quotient bits shift in
  logic [N-1:0]    dvs_q;
  logic [N-1:0]    a_q;     // original dividend, returned as R on divide by zero
  logic            qneg_q, rneg_q, dz_q, ovf_q;
  logic [N-1:0]    q_q, r_q;
  logic            valid_q, busy_q;

  logic [N-1:0]    a_mag, b_mag;
  logic            dz, ovf;
  logic [N:0]      shifted;
  logic [N+1:0]    trial;
  logic            borrow;
  logic            unused_trial;

  always_comb begin
    a_mag   = (bus.signed_op && bus.A[N-1]) ? -bus.A : bus.A;
    b_mag   = (bus.signed_op && bus.B[N-1]) ? -bus.B : bus.B;
    dz      = (bus.B == '0);
    ovf     = bus.signed_op && (bus.A == {1'b1, {(N-1){1'b0}}}) && (bus.B == '1);
    // N+1-bit shifted remainder; the extra top bit of trial is the borrow.
    shifted = {rem_q, quo_q[N-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    borrow  = trial[N+1];
    // The difference is always below the divisor, so bit N is never needed.
    unused_trial = trial[N];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= a_mag;
            dvs_q  <= b_mag;
            a_q    <= bus.A;
            qneg_q <= bus.signed_op & (bus.A[N-1] ^ bus.B[N-1]);
            rneg_q <= bus.signed_op & bus.A[N-1];
            dz_q   <= dz;
            ovf_q  <= ovf;
            busy_q <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            state_q <= (dz || ovf) ? StFix : StCalc;
`else
            state_q <= StCalc;
`endif
          end
        end
        StCalc: begin
          if (!borrow) begin
            rem_q <= trial[N-1:0];
            quo_q <= {quo_q[N-2:0], 1'b1};
          end else begin
            rem_q <= shifted[N-1:0];
            quo_q <= {quo_q[N-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (dz_q) begin
            q_q <= '1;
            r_q <= a_q;
          end else if (ovf_q) begin
            q_q <= {1'b1, {(N-1){1'b0}}};
            r_q <= '0;
          end else begin
            q_q <= qneg_q ? -quo_q : quo_q;
            r_q <= rneg_q ? -rem_q : rem_q;
          end
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
endmodule
